spi_xfer_arbiter: RTL and testbench

- Shares one SPI peripheral between NREQ requesters, for example the CPU load/store path and a DMA channel.
- Arbitrates round-robin and drives the peripheral's APB slave port: a write starts the transfer, then the block waits for the peripheral's transfer-done interrupt.
- After the interrupt it reads the received word back over APB and returns it to the granted requester.
- Sits between the requesters and the SPI peripheral's PSEL/PENABLE/PWRITE/PWDATA/PREADY/PRDATA/interrupt pins.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/rr_arbiter_spi.sv | 42 ++++
 rtl/spi_xfer_arbiter.sv | 138 +++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer arbiter: FSM encoding,
// APB direction values, default transfer timeout and width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_SETUP  = 3'd1,
        S_WR_ACCESS = 3'd2,
        S_WAIT_XFER = 3'd3,
        S_RD_SETUP  = 3'd4,
        S_RD_ACCESS = 3'd5,
        S_DONE      = 3'd6
    } xfer_state_t;

    localparam logic APB_WRITE = 1'b1;
    localparam logic APB_READ  = 1'b0;

    localparam int unsigned TIMEOUT_DEFAULT = 1023;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_spi.sv
// Round-robin one-hot pick: first set req bit at or above rr_ptr,
// wrapping past NREQ-1 back to requester 0.
module rr_arbiter_spi
    import spi_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            any
);

    logic [PW:0]   sum;
    logic [PW-1:0] sel;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        sel     = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            sel = sum[PW-1:0];
            if (!found && req[sel]) begin
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
                found    = 1'b1;
            end
        end
    end

    assign any = found;

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one APB-attached SPI peripheral between NREQ requesters:
// round-robin grant, APB write, wait for irq edge, APB read back.
module spi_xfer_arbiter
    import spi_pkg::*;
#(
    parameter int          NREQ    = 2,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          rdata,
    output logic                 err,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    input  logic                 PREADY,
    input  logic [31:0]          PRDATA,
    input  logic                 spi_irq
);

    localparam int PW = idx_w(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    xfer_state_t   state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic [TW-1:0] timer;
    logic          irq_q;

    logic [NREQ-1:0] pick;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic            irq_rise;

    rr_arbiter_spi #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .gnt     (pick),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // A level already high on WAIT_XFER entry is filtered out here.
    assign irq_rise = spi_irq & ~irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            timer     <= '0;
            irq_q     <= 1'b0;
            grant     <= '0;
            done      <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
        end else begin
            irq_q <= spi_irq;
            done  <= '0;
            unique case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        grant     <= pick;
                        grant_idx <= pick_idx;
                        PWDATA    <= req_wdata[32*pick_idx +: 32];
                        err       <= 1'b0;
                        state     <= S_WR_SETUP;
                    end
                end
                S_WR_SETUP: begin
                    if (PREADY) begin
                        PSEL    <= 1'b1;
                        PWRITE  <= APB_WRITE;
                        PENABLE <= 1'b0;
                        state   <= S_WR_ACCESS;
                    end
                end
                S_WR_ACCESS: begin
                    PENABLE <= 1'b1;
                    timer   <= '0;
                    state   <= S_WAIT_XFER;
                end
                S_WAIT_XFER: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    PWRITE  <= 1'b0;
                    if (irq_rise) begin
                        PSEL   <= 1'b1;
                        PWRITE <= APB_READ;
                        state  <= S_RD_SETUP;
                    end else if (timer == TW'(TIMEOUT)) begin
                        err   <= 1'b1;
                        rdata <= '0;
                        done  <= grant;
                        state <= S_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RD_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= S_RD_ACCESS;
                end
                S_RD_ACCESS: begin
                    if (PREADY) begin
                        rdata   <= PRDATA;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        done    <= grant;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    grant  <= '0;
                    rr_ptr <= (grant_idx == PW'(NREQ - 1)) ?
                              '0 : grant_idx + 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed and randomized transfers against a queue-level model of
// round-robin arbitration and the SPI peripheral's APB/irq behaviour.
module tb_spi_xfer_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 1023;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [32*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic [31:0]        rdata;
    logic               err;
    logic               PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [31:0]        PWDATA;
    logic               PREADY;
    logic [31:0]        PRDATA;
    logic               spi_irq;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int ptr    = 0;

    always #5 clk = ~clk;

    spi_xfer_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_wdata (req_wdata),
        .grant     (grant),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .spi_irq   (spi_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Reference arbitration: first pending requester at or after ptr.
    function automatic int pick(input logic [NREQ-1:0] p, input int from);
        for (int i = 0; i < NREQ; i++) begin
            if (p[(from + i) % NREQ]) return (from + i) % NREQ;
        end
        return 0;
    endfunction

    // Runs one transfer starting with the DUT idle; the bench plays the
    // SPI peripheral and the granted requester.
    task automatic do_xfer(input int win, input int irq_dly,
                           input int rd_wait, input logic [31:0] rd_val,
                           input bit to_mode, input bit stale);
        int t0 = cyc;
        int wr_cyc = -1;
        int rs_cyc = -1;
        int rd_cyc = -1;
        int rise = -1;
        int dn = -1;
        int first = -1;
        int nwr = 0;
        int nrd = 0;
        int stall = 0;
        int acc = 0;
        logic [31:0] exp_wd = req_wdata[32*win +: 32];
        logic [31:0] wd = '0;
        logic [NREQ-1:0] oh = '0;
        logic [NREQ-1:0] d_done = '0;
        logic [NREQ-1:0] d_grant = '0;
        logic [31:0] d_rdata = '0;
        logic d_err = 1'b0;
        logic d_psel = 1'b0;
        logic [31:0] exp_rd;
        oh[win] = 1'b1;
        exp_rd = to_mode ? 32'h0 : rd_val;
        spi_irq = stale;
        PREADY = 1'b1;
        PRDATA = rd_val;
        for (int k = 0; k < 2000 && dn < 0; k++) begin
            step();
            if (PSEL && first < 0) first = cyc;
            if (PSEL && PENABLE && PWRITE) begin
                nwr++;
                wr_cyc = cyc;
                wd = PWDATA;
            end
            if (PSEL && !PENABLE && !PWRITE && rs_cyc < 0) rs_cyc = cyc;
            if (|done) begin
                dn = cyc;
                d_done = done;
                d_grant = grant;
                d_rdata = rdata;
                d_err = err;
                d_psel = PSEL;
                req[win] = 1'b0;
            end
            if (wr_cyc >= 0 && !to_mode) begin
                if (stale && cyc - wr_cyc == 4) spi_irq = 1'b0;
                if (cyc - wr_cyc == irq_dly) begin
                    spi_irq = 1'b1;
                    rise = cyc;
                end
            end
            PREADY = 1'b1;
            if (PSEL && PENABLE && !PWRITE) begin
                PREADY = (acc >= rd_wait);
                acc++;
                if (PREADY) begin
                    nrd++;
                    rd_cyc = cyc;
                    spi_irq = 1'b0;
                end else begin
                    stall++;
                end
            end
        end
        chk("done_seen", 32'(dn >= 0), 1);
        chk("lat_req_psel", first - t0, 2);
        chk("n_writes", nwr, 1);
        chk("pwdata", wd, exp_wd);
        chk("done_onehot", d_done, oh);
        chk("grant_at_done", d_grant, oh);
        chk("psel_at_done", d_psel, 0);
        chk("err_at_done", d_err, to_mode);
        chk("rdata_at_done", d_rdata, exp_rd);
        if (to_mode) begin
            chk("to_reads", nrd, 0);
            chk("to_latency", dn - wr_cyc, TIMEOUT + 1);
        end else begin
            chk("n_reads", nrd, 1);
            chk("rd_stall_cycles", stall, rd_wait);
            chk("rd_to_done", dn - rd_cyc, 1);
            chk("irq_to_rdsetup", rs_cyc - rise, 1);
        end
        step();
        chk("done_one_cycle", done, 0);
        chk("grant_cleared", grant, 0);
        chk("rdata_hold", rdata, exp_rd);
        chk("err_hold", err, to_mode);
    endtask

    initial begin
        int w;
        int seen_done;
        bit st;
        rst = 1'b1;
        req = '0;
        req_wdata = '0;
        PREADY = 1'b1;
        PRDATA = '0;
        spi_irq = 1'b0;
        step();
        step();
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_pwdata", PWDATA, 0);
        rst = 1'b0;

        // Both requesters held: grants alternate, winner re-asserts.
        req_wdata[31:0]  = 32'h1111_0000;
        req_wdata[63:32] = 32'h2222_0000;
        req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            w = pick(req, ptr);
            do_xfer(w, $urandom_range(3, 20), 0, $urandom, 1'b0, 1'b0);
            ptr = (w + 1) % NREQ;
            req[w] = 1'b1;
        end
        req = '0;

        // Single request, irq 40 cycles after the write.
        req_wdata[31:0] = 32'hA5A5_0001;
        req = 2'b01;
        w = pick(req, ptr);
        do_xfer(w, 40, 0, 32'h1234_5678, 1'b0, 1'b0);
        ptr = (w + 1) % NREQ;

        // irq never rises: timeout path.
        req_wdata[63:32] = $urandom;
        req = 2'b10;
        w = pick(req, ptr);
        do_xfer(w, 0, 0, $urandom, 1'b1, 1'b0);
        ptr = (w + 1) % NREQ;

        // PREADY low for 5 read access cycles.
        req_wdata[31:0] = $urandom;
        req = 2'b01;
        w = pick(req, ptr);
        do_xfer(w, 10, 5, $urandom, 1'b0, 1'b0);
        ptr = (w + 1) % NREQ;

        // Stale irq level on WAIT_XFER entry.
        req_wdata[63:32] = $urandom;
        req = 2'b10;
        w = pick(req, ptr);
        do_xfer(w, 12, 0, $urandom, 1'b0, 1'b1);
        ptr = (w + 1) % NREQ;

        // Reset while waiting for the irq, with rr_ptr pointing at 1.
        req = 2'b01;
        w = pick(req, ptr);
        do_xfer(w, 5, 0, $urandom, 1'b0, 1'b0);
        ptr = (w + 1) % NREQ;
        req = 2'b10;
        seen_done = 0;
        for (int k = 0; k < 7; k++) begin
            step();
            if (|done) seen_done++;
        end
        chk("pre_rst_grant", grant, 2'b10);
        chk("pre_rst_no_done", seen_done, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_grant", grant, 0);
        chk("async_rst_psel", PSEL, 0);
        chk("async_rst_penable", PENABLE, 0);
        chk("async_rst_done", done, 0);
        step();
        chk("rst_held_done", done, 0);
        rst = 1'b0;
        ptr = 0;
        req = 2'b11;
        w = pick(req, ptr);
        do_xfer(w, 8, 1, $urandom, 1'b0, 1'b0);
        ptr = (w + 1) % NREQ;

        // Randomized traffic.
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    req[i] = 1'b1;
                    req_wdata[32*i +: 32] = $urandom;
                end
            end
            if (req == '0) begin
                w = $urandom_range(0, NREQ - 1);
                req[w] = 1'b1;
                req_wdata[32*w +: 32] = $urandom;
            end
            w = pick(req, ptr);
            st = ($urandom_range(0, 3) == 0);
            do_xfer(w, st ? $urandom_range(6, 30) : $urandom_range(1, 30),
                    $urandom_range(0, 3), $urandom, 1'b0, st);
            ptr = (w + 1) % NREQ;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
